// File: rtl/ir_packet_scheduler_pkg.sv
// ir_packet_scheduler_pkg: shared states, command bit map, default timing and command sanitising.
package ir_packet_scheduler_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, SEND, HOLD} state_t;
    typedef logic [3:0] cmd_t;
    localparam int RIGHT = 0;
    localparam int LEFT = 1;
    localparam int BACKWARD = 2;
    localparam int FORWARD = 3;
    localparam int DEF_PERIOD_CYCLES = 10_000_000;
    localparam int DEF_HOLD_CYCLES = 2_000_000;
    localparam int DEF_TIMEOUT_PACKETS = 20;
    localparam int DEF_COUNTER_WIDTH = 24;
    // Opposing directions cancel each other rather than letting one win.
    function automatic cmd_t sanitise(input cmd_t c);
        sanitise = c;
        if (c[RIGHT] && c[LEFT]) begin
            sanitise[RIGHT] = 1'b0;
            sanitise[LEFT] = 1'b0;
        end
        if (c[BACKWARD] && c[FORWARD]) begin
            sanitise[BACKWARD] = 1'b0;
            sanitise[FORWARD] = 1'b0;
        end
    endfunction
endpackage

// File: rtl/ir_packet_scheduler_if.sv
// ir_packet_scheduler_if: processor bus command write and IR transmitter packet outputs.
interface ir_packet_scheduler_if;
    import ir_packet_scheduler_pkg::*;
    logic BUS_CMD_WE;
    cmd_t BUS_CMD;
    logic SEND_PACKET;
    cmd_t COMMAND;
    modport master(output BUS_CMD_WE, BUS_CMD, input SEND_PACKET, COMMAND);
    modport slave(input BUS_CMD_WE, BUS_CMD, output SEND_PACKET, COMMAND);
endinterface

// File: rtl/ir_packet_scheduler_period.sv
// ir_period_timer: free-running period counter, wraps at PERIOD_CYCLES-1 and flags the wrap cycle.
module ir_period_timer #(
    parameter int COUNTER_WIDTH = 24,
    parameter int PERIOD_CYCLES = 10_000_000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    output logic wrap
);
    localparam logic [COUNTER_WIDTH-1:0] LAST = COUNTER_WIDTH'(PERIOD_CYCLES - 1);
    logic [COUNTER_WIDTH-1:0] count;
    assign wrap = count == LAST;
    always_ff @(posedge CLK or negedge RESET)
        if (!RESET) count <= '0;
        else count <= (clear || wrap) ? '0 : count + 1'b1;
endmodule

// File: rtl/ir_packet_scheduler.sv
// ir_packet_scheduler: periodic IR packet issue with command arbitration, sanitising and a
// safety stop that clears the bus command after too many packets without a bus write.
module ir_packet_scheduler
    import ir_packet_scheduler_pkg::*;
#(
    parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int TIMEOUT_PACKETS = DEF_TIMEOUT_PACKETS,
    parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH
) (
    input  logic CLK,
    input  logic RESET,
    input  logic ENABLE,
    input  logic SW_OVERRIDE,
    input  cmd_t SW_CMD,
    ir_packet_scheduler_if.slave bus,
    output logic BUSY,
    output logic TIMED_OUT,
    output logic [7:0] PACKET_COUNT
);
    localparam logic [COUNTER_WIDTH-1:0] HOLD_LAST = COUNTER_WIDTH'(HOLD_CYCLES - 1);
    state_t state, state_nx;
    logic wrap, send_entry, expire;
    logic [COUNTER_WIDTH-1:0] hold_count;
    logic [4:0] timeout_count, timeout_nx;
    cmd_t pending;
    ir_period_timer #(.COUNTER_WIDTH(COUNTER_WIDTH), .PERIOD_CYCLES(PERIOD_CYCLES)) u_period (
        .CLK(CLK),
        .RESET(RESET),
        .clear(state == IDLE),
        .wrap(wrap)
    );
    always_comb begin
        state_nx = state == IDLE ? (ENABLE ? WAIT : IDLE)
                 : state == WAIT ? (!ENABLE ? IDLE : wrap ? SEND : WAIT)
                 : state == SEND ? HOLD
                 : hold_count == HOLD_LAST ? (ENABLE ? WAIT : IDLE) : HOLD;
        send_entry = state_nx == SEND;
        // A bus write wins over a same-cycle packet increment.
        timeout_nx = bus.BUS_CMD_WE ? 5'd0
                   : (send_entry && timeout_count != 5'h1f) ? timeout_count + 5'd1 : timeout_count;
        expire = int'(timeout_nx) >= TIMEOUT_PACKETS;
    end
    always_ff @(posedge CLK or negedge RESET)
        if (!RESET) begin
            state <= IDLE;
            hold_count <= '0;
            timeout_count <= '0;
            pending <= '0;
            bus.SEND_PACKET <= 1'b0;
            bus.COMMAND <= '0;
            BUSY <= 1'b0;
            TIMED_OUT <= 1'b0;
            PACKET_COUNT <= '0;
        end else begin
            state <= state_nx;
            hold_count <= state == HOLD ? hold_count + 1'b1 : '0;
            timeout_count <= timeout_nx;
            pending <= bus.BUS_CMD_WE ? bus.BUS_CMD : expire ? '0 : pending;
            bus.SEND_PACKET <= send_entry;
            bus.COMMAND <= send_entry ? sanitise(SW_OVERRIDE ? SW_CMD : pending) : bus.COMMAND;
            BUSY <= state_nx == SEND || state_nx == HOLD;
            TIMED_OUT <= expire;
            PACKET_COUNT <= send_entry ? PACKET_COUNT + 8'd1 : PACKET_COUNT;
        end
endmodule
